fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the pipelined core. It owns the fetch program counter and issues requests to instruction memory over a req/ack handshake. Returned instructions are held in a DEPTH-entry prefetch buffer, so fetch keeps running while the hazard unit stalls. It presents the buffer head as InstrF to the Fetch→Decode pipeline register and redirects to a branch target from Execute.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: prefetch buffer entries; legal values 2 or 4.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- StallF  in  1  hazard unit: hold buffer head, no pop.
- BranchTakenE  in  1  redirect request from Execute.
- BranchTargetE  in  32  redirect target address.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address, word-aligned.
- imem_ack  in  1  request completed; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- InstrF  out  32  buffer head instruction; 0 when buffer empty.
- InstrValidF  out  1  buffer non-empty.
- PCF  out  32  address of InstrF; 0 when empty.
- PCPlus4F  out  32  PCF+4 mod 2^32; 0 when empty.

## Operation
- State: fpc (next fetch address), req_addr (address of the request in flight), FIFO of {instr, pc} with count, FSM {FETCH, DROP}.
- Reset (reset=0, async): fpc=RESET_PC, count=0, FSM=FETCH. All outputs read 0 except imem_addr=RESET_PC. imem_req=0 while reset is asserted.
- FETCH:
  - imem_req=1 iff count<DEPTH.
  - imem_addr=fpc. req_addr tracks fpc.
  - On req&ack: push {imem_rdata, fpc} and set fpc=fpc+4 (32-bit wrap).
- Address stability: once imem_req rises, it and imem_addr stay constant until ack. count cannot rise without ack, so this holds by construction.
- Pop: the head is popped at the edge when InstrValidF=1 and StallF=0. Push and pop in the same cycle leave count unchanged. There is no bypass: pushed data is visible the next cycle.
- Redirect (BranchTakenE=1 at an edge) has priority over push, pop and StallF:
  - FIFO is flushed (count=0) and fpc=BranchTargetE.
  - If imem_req=1 and imem_ack=0 that cycle, FSM→DROP; req_addr keeps the old address.
  - If acked that cycle, the returned data is discarded and FSM stays in FETCH.
- DROP:
  - imem_req=1 and imem_addr=req_addr (old address).
  - Nothing is pushed.
  - On ack, the data is discarded and FSM→FETCH. The next cycle issues at fpc.
  - A further redirect in DROP only updates fpc and flushes.
- StallF=1 with buffer non-empty: InstrF, PCF and PCPlus4F are held. Fetch continues until the buffer is full.
- Empty buffer: InstrF=0 (bubble, same encoding the Decode register uses for flush).

## Timing
- Zero-wait memory (ack in the request cycle): request at edge n, InstrF valid at n+1. Steady state is 1 instruction/cycle.
- N-cycle memory: one transaction outstanding; throughput is 1 per N cycles.
- Redirect with no pending request: imem_addr=target in the cycle after the redirect edge. The first target instruction appears in InstrF one cycle after its ack.
- Redirect with a pending request: the target request issues in the cycle after the old request's ack.
- All outputs derive from registers or FSM state. No combinational path from imem_rdata to InstrF.
- Asserting reset mid-transaction (including in DROP) aborts immediately. Memory shares the same reset.

## Test plan
- Reset release, imem_ack tied 1, imem_rdata=addr^32'hA5A5_0000, StallF=0 → imem_addr 0,4,8,C…; InstrF 0xA5A50000, 0xA5A50004… one cycle later; PCPlus4F=PCF+4.
- Zero-wait memory, StallF=1 for 4 cycles → buffer fills to DEPTH, imem_req drops, InstrF held. On release the sequence continues with no loss or duplicate.
- Redirect to 0x100 with 2 entries buffered, zero-wait → next cycle InstrValidF=0, InstrF=0, imem_addr=0x100. Then InstrF=word(0x100).
- 3-cycle memory, redirect to 0x200 while 0x8 is pending → imem_addr stays 0x8 until ack, word(0x8) never appears on InstrF, then request 0x200.
- RESET_PC=0xFFFF_FFFC → second request at 0x0; PCPlus4F of first instruction=0x0.
- Assert reset during DROP → all outputs reset asynchronously. After release, the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage holds imem_req and imem_addr steady until imem_ack.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to imem over req/ack and
// buffers returned words in a small prefetch FIFO presented to Decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallF,
    input  logic         BranchTakenE,
    input  logic [31:0]  BranchTargetE,
    fetch_stage_if.master imem,
    output logic [31:0]  InstrF,
    output logic         InstrValidF,
    output logic [31:0]  PCF,
    output logic [31:0]  PCPlus4F
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {FETCH, DROP} state_t;

    state_t             state;
    state_t             state_next;
    logic               run;
    logic [31:0]        fpc;
    logic [31:0]        req_addr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        instr_buf [DEPTH];
    logic [31:0]        pc_buf    [DEPTH];
    logic               full;
    logic               push;
    logic               pop;

    assign full = (count == CNT_W'(DEPTH));

    // run keeps imem_req low while reset is held, without a combinational path from reset
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = fpc;
        state_next     = state;
        case (state)
            FETCH: begin
                imem.imem_req  = run & ~full;
                imem.imem_addr = fpc;
                if (BranchTakenE && imem.imem_req && !imem.imem_ack)
                    state_next = DROP;
            end
            DROP: begin
                imem.imem_req  = run;
                imem.imem_addr = req_addr;
                if (imem.imem_ack)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    assign push = (state == FETCH) & imem.imem_req & imem.imem_ack & ~BranchTakenE;
    assign pop  = InstrValidF & ~StallF & ~BranchTakenE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            run      <= 1'b0;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_next;
            // in DROP req_addr must keep the abandoned address until its ack
            if (state == FETCH)
                req_addr <= fpc;
            if (BranchTakenE) begin
                fpc    <= BranchTargetE;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fpc    <= fpc + 32'd4;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_buf[wr_ptr] <= imem.imem_rdata;
            pc_buf[wr_ptr]    <= fpc;
        end
    end

    assign InstrValidF = (count != '0);
    assign InstrF      = InstrValidF ? instr_buf[rd_ptr]       : 32'd0;
    assign PCF         = InstrValidF ? pc_buf[rd_ptr]          : 32'd0;
    assign PCPlus4F    = InstrValidF ? pc_buf[rd_ptr] + 32'd4  : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers requests with
// word(addr) = addr ^ 32'hA5A5_0000 and a monitor checks every head consumed.
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f;
    logic        branch_taken_e;
    logic [31:0] branch_target_e;
    logic [31:0] instr_f;
    logic        instr_valid_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;

    logic        stall2;
    logic        branch2;
    logic [31:0] target2;
    logic [31:0] instr2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          lat       = 1;
    int          mem_cnt   = 0;
    logic [31:0] held_addr;
    logic [31:0] mon_pc;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_stage_if m1 ();
    fetch_stage_if m2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .StallF        (stall_f),
        .BranchTakenE  (branch_taken_e),
        .BranchTargetE (branch_target_e),
        .imem          (m1.master),
        .InstrF        (instr_f),
        .InstrValidF   (instr_valid_f),
        .PCF           (pc_f),
        .PCPlus4F      (pc_plus4_f)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .StallF        (stall2),
        .BranchTakenE  (branch2),
        .BranchTargetE (target2),
        .imem          (m2.master),
        .InstrF        (instr2),
        .InstrValidF   (valid2),
        .PCF           (pc2),
        .PCPlus4F      (pc4_2)
    );

    // zero-wait memory for the wrap-around instance
    assign m2.imem_ack   = m2.imem_req;
    assign m2.imem_rdata = m2.imem_addr ^ K;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // memory with lat-cycle latency; decides ack for the next rising edge
    always @(negedge clk) begin
        if (!reset) begin
            mem_cnt     = 0;
            m1.imem_ack = 1'b0;
        end else if (m1.imem_req) begin
            if (mem_cnt == 0) held_addr = m1.imem_addr;
            m1.imem_rdata = m1.imem_addr ^ K;
            if (mem_cnt == lat - 1) begin
                m1.imem_ack = 1'b1;
                mem_cnt     = 0;
                if (lat > 1) check("addr_stable", m1.imem_addr, held_addr);
            end else begin
                m1.imem_ack = 1'b0;
                mem_cnt++;
            end
        end else begin
            m1.imem_ack = 1'b0;
            mem_cnt     = 0;
        end
    end

    // monitor: compares the head whenever it is presented; pops when it is consumed
    always @(negedge clk) begin
        if (reset && instr_valid_f && !branch_taken_e) begin
            if (exp_q.size() == 0) begin
                if (!stall_f) begin
                    total_cnt++;
                    $display("FAIL unexpected_instr: got pc %h expected none", pc_f);
                end
            end else begin
                mon_pc = exp_q[0];
                check("instr", instr_f, mon_pc ^ K);
                check("pc", pc_f, mon_pc);
                check("pc_plus4", pc_plus4_f, mon_pc + 32'd4);
                if (!stall_f) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        stall_f = 1'b0;
        while (exp_q.size() != 0 && k < 300) begin
            step();
            k++;
        end
        stall_f = 1'b1;
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL %s_timeout: %0d entries left, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (m1.imem_req && k < 50) begin
            step();
            k++;
        end
        check(nm, 32'(m1.imem_req), 32'd0);
    endtask

    initial begin
        stall_f = 1'b0; branch_taken_e = 1'b0; branch_target_e = 32'd0;
        stall2 = 1'b1; branch2 = 1'b0; target2 = 32'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        step();
        step();
        check("rst_req", 32'(m1.imem_req), 32'd0);
        check("rst_addr", m1.imem_addr, 32'h0000_0000);
        check("rst_valid", 32'(instr_valid_f), 32'd0);
        check("rst_instr", instr_f, 32'd0);
        check("rst_pc", pc_f, 32'd0);
        check("rst_pc4", pc_plus4_f, 32'd0);
        check("rst_addr_wrap", m2.imem_addr, 32'hFFFF_FFFC);

        // streaming, zero-wait memory
        push_seq(32'h0, 8);
        reset = 1'b1;
        step();
        step();
        check("wrap_valid", 32'(valid2), 32'd1);
        check("wrap_pc", pc2, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_2, 32'h0000_0000);
        check("wrap_instr", instr2, 32'h5A5A_FFFC);
        check("wrap_addr", m2.imem_addr, 32'h0000_0000);
        drain("stream");
        check("wrap_full_req", 32'(m2.imem_req), 32'd0);
        check("wrap_held_pc", pc2, 32'hFFFF_FFFC);

        // stall four cycles: head held, buffer fills, request drops
        push_seq(32'h20, 8);
        repeat (4) step();
        check("stall_req", 32'(m1.imem_req), 32'd0);
        check("stall_valid", 32'(instr_valid_f), 32'd1);
        drain("stall_release");

        // redirect with two entries buffered
        wait_idle("full_before_redirect");
        branch_taken_e = 1'b1; branch_target_e = 32'h100;
        step();
        branch_taken_e = 1'b0;
        exp_q.delete();
        check("redir_valid", 32'(instr_valid_f), 32'd0);
        check("redir_instr", instr_f, 32'd0);
        check("redir_addr", m1.imem_addr, 32'h100);
        check("redir_req", 32'(m1.imem_req), 32'd1);
        push_seq(32'h100, 4);
        drain("redirect");

        // 3-cycle memory, redirect while 0x8 is pending
        wait_idle("full_before_slow");
        lat = 3;
        branch_taken_e = 1'b1; branch_target_e = 32'h8;
        step();
        branch_taken_e = 1'b0;
        check("slow_addr", m1.imem_addr, 32'h8);
        step();
        branch_taken_e = 1'b1; branch_target_e = 32'h200;
        step();
        branch_taken_e = 1'b0;
        check("drop_addr", m1.imem_addr, 32'h8);
        check("drop_req", 32'(m1.imem_req), 32'd1);
        check("drop_valid", 32'(instr_valid_f), 32'd0);
        push_seq(32'h200, 3);
        stall_f = 1'b0;
        step();
        check("after_drop_addr", m1.imem_addr, 32'h200);
        check("after_drop_valid", 32'(instr_valid_f), 32'd0);
        drain("after_drop");

        // reset asserted while in DROP
        wait_idle("full_before_reset");
        branch_taken_e = 1'b1; branch_target_e = 32'h300;
        step();
        branch_target_e = 32'h400;
        step();
        branch_taken_e = 1'b0;
        check("drop2_addr", m1.imem_addr, 32'h300);
        #2 reset = 1'b0;
        #1;
        check("async_req", 32'(m1.imem_req), 32'd0);
        check("async_addr", m1.imem_addr, 32'h0);
        check("async_valid", 32'(instr_valid_f), 32'd0);
        check("async_instr", instr_f, 32'd0);
        check("async_pc", pc_f, 32'd0);
        check("async_pc4", pc_plus4_f, 32'd0);
        step();
        reset = 1'b1;
        push_seq(32'h0, 3);
        step();
        check("post_reset_addr", m1.imem_addr, 32'h0);
        check("post_reset_req", 32'(m1.imem_req), 32'd1);
        drain("post_reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
